pipeline_hazard_ctrl: RTL and testbench

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

---
 rtl/pipeline_ctrl_pkg.sv | 26 ++
 rtl/pipeline_hazard_ctrl_fwd_select.sv | 27 ++
 rtl/pipeline_hazard_ctrl.sv | 156 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   hz_state_e : controller state encoding (RUN / MEM_WAIT / ERROR)
//   FWD_*      : EX operand forwarding select codes
//   reg_hit    : "later stage writes the register this operand reads"
package pipeline_ctrl_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'b00,
    ST_MEM_WAIT = 2'b01,
    ST_ERROR    = 2'b10
  } hz_state_e;

  localparam logic [1:0] FWD_RF   = 2'b00;
  localparam logic [1:0] FWD_EXDM = 2'b01;
  localparam logic [1:0] FWD_WB   = 2'b10;

  // r0 is hardwired to zero, so a write to it never produces a forward.
  function automatic logic reg_hit(input logic             we,
                                   input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] src);
    return we && (rd != '0) && (rd == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_fwd_select.sv
// Forwarding select for one EX operand.
//   src          : operand register number read by the EX instruction
//   dm_rd/dm_reg_write : DM-stage destination and write enable
//   wb_rd/wb_reg_write : WB-stage destination and write enable
//   sel          : FWD_EXDM, FWD_WB or FWD_RF
// The DM stage holds the younger result, so it wins when both stages match.
module fwd_select
  import pipeline_ctrl_pkg::*;
(
  input  logic [4:0] src,
  input  logic [4:0] dm_rd,
  input  logic       dm_reg_write,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_RF;
    if (reg_hit(dm_reg_write, dm_rd, src)) begin
      sel = FWD_EXDM;
    end else if (reg_hit(wb_reg_write, wb_rd, src)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline (IF, ID, EX, DM, WB).
// Inputs : clk, reset (async, active-low), ID/EX/DM/WB register numbers and
//          write enables, ex_mem_read, ex_branch_taken, dm_busy.
// Outputs: pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold
//          (same-cycle pipeline control), fwd_a/fwd_b (EX operand selects),
//          stall_flag, sticky mem_timeout, saturating stall_cycles, state.
// A data-memory stall freezes the whole pipe; after MAX_WAIT consecutive busy
// cycles the controller locks in ERROR until reset.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_rs,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic [4:0]       dm_rd,
  input  logic             dm_reg_write,
  input  logic [4:0]       wb_rd,
  input  logic             wb_reg_write,
  input  logic             ex_branch_taken,
  input  logic             dm_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_hold,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             stall_flag,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [1:0]       state
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_d, wait_inc;
  logic [CNT_W-1:0]  stall_cnt_q;
  logic              timeout_q, timeout_set;
  logic              load_use;
  logic [1:0]        fwd_a_raw, fwd_b_raw;

  fwd_select u_fwd_rs (
    .src          (ex_rs),
    .dm_rd        (dm_rd),
    .dm_reg_write (dm_reg_write),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .sel          (fwd_a_raw)
  );

  fwd_select u_fwd_rt (
    .src          (ex_rt),
    .dm_rd        (dm_rd),
    .dm_reg_write (dm_reg_write),
    .wb_rd        (wb_rd),
    .wb_reg_write (wb_reg_write),
    .sel          (fwd_b_raw)
  );

  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));

  assign wait_inc = wait_cnt_q + WAIT_W'(1);

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_cnt_q;
    timeout_set  = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    if_id_flush  = 1'b0;
    id_ex_bubble = 1'b0;
    pipe_hold    = 1'b0;

    case (state_q)
      ST_RUN, ST_MEM_WAIT: begin
        if (dm_busy) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          pipe_hold   = 1'b1;
          state_d     = ST_MEM_WAIT;
          wait_d      = (state_q == ST_RUN) ? WAIT_W'(1) : wait_inc;
          if (wait_d >= WAIT_W'(MAX_WAIT)) begin
            state_d     = ST_ERROR;
            timeout_set = 1'b1;
          end
        end else begin
          // Leaving MEM_WAIT behaves exactly like RUN in this cycle, so any
          // branch or load-use hazard held during the freeze is applied now.
          state_d = ST_RUN;
          wait_d  = '0;
          if (ex_branch_taken) begin
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
          end else if (load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
          end
        end
      end
      default: begin
        // ERROR, and the unused 2'b11 encoding, hold the pipe frozen.
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        pipe_hold   = 1'b1;
        state_d     = ST_ERROR;
      end
    endcase

    // Reset overrides the pipeline controls combinationally, before any edge.
    if (!reset) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      if_id_flush  = 1'b0;
      id_ex_bubble = 1'b1;
      pipe_hold    = 1'b0;
    end
  end

  assign stall_flag   = reset && !pc_write;
  assign fwd_a        = reset ? fwd_a_raw : FWD_RF;
  assign fwd_b        = reset ? fwd_b_raw : FWD_RF;
  assign mem_timeout  = timeout_q;
  assign stall_cycles = stall_cnt_q;
  assign state        = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_d;
      if (timeout_set) begin
        timeout_q <= 1'b1;
      end
      if (stall_flag && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MAX_WAIT=16, CNT_W=4 so the
// stall counter saturates at 15 within a short run).
module tb_pipeline_hazard_ctrl;

  localparam int MAX_WAIT = 16;
  localparam int CNT_W    = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [4:0]       id_rs, id_rt, ex_rs, ex_rt, ex_rd, dm_rd, wb_rd;
  logic             id_uses_rt, ex_mem_read, dm_reg_write, wb_reg_write;
  logic             ex_branch_taken, dm_busy;
  logic             pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_hold;
  logic [1:0]       fwd_a, fwd_b, state;
  logic             stall_flag, mem_timeout;
  logic [CNT_W-1:0] stall_cycles;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_rs           (ex_rs),
    .ex_rt           (ex_rt),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .dm_rd           (dm_rd),
    .dm_reg_write    (dm_reg_write),
    .wb_rd           (wb_rd),
    .wb_reg_write    (wb_reg_write),
    .ex_branch_taken (ex_branch_taken),
    .dm_busy         (dm_busy),
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_bubble    (id_ex_bubble),
    .pipe_hold       (pipe_hold),
    .fwd_a           (fwd_a),
    .fwd_b           (fwd_b),
    .stall_flag      (stall_flag),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles),
    .state           (state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0;
    ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0; ex_mem_read = 1'b0;
    dm_rd = 5'd0; dm_reg_write = 1'b0; wb_rd = 5'd0; wb_reg_write = 1'b0;
    ex_branch_taken = 1'b0; dm_busy = 1'b0;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    ex_rs = 5'd7; dm_rd = 5'd7; dm_reg_write = 1'b1;
    #2;
    chk("rst_pc_write", pc_write, 0);
    chk("rst_if_id_write", if_id_write, 0);
    chk("rst_bubble", id_ex_bubble, 1);
    chk("rst_flush", if_id_flush, 0);
    chk("rst_hold", pipe_hold, 0);
    chk("rst_stall_flag", stall_flag, 0);
    chk("rst_fwd_a", fwd_a, 0);
    chk("rst_state", state, 0);
    chk("rst_stall_cycles", stall_cycles, 0);
    chk("rst_timeout", mem_timeout, 0);
    reset = 1'b1;
    idle();
    step();

    // Normal flow
    #1;
    chk("run_pc_write", pc_write, 1);
    chk("run_if_id_write", if_id_write, 1);
    chk("run_bubble", id_ex_bubble, 0);
    chk("run_stall_flag", stall_flag, 0);

    // Load-use on rs: one stall cycle
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
    #1;
    chk("lu_pc_write", pc_write, 0);
    chk("lu_if_id_write", if_id_write, 0);
    chk("lu_bubble", id_ex_bubble, 1);
    chk("lu_stall_flag", stall_flag, 1);
    chk("lu_cnt_before", stall_cycles, 0);
    step();
    idle();
    #1;
    chk("lu_cnt_after", stall_cycles, 1);
    chk("lu_next_pc_write", pc_write, 1);

    // Load to r0 never stalls
    ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
    #1;
    chk("lu_r0_pc_write", pc_write, 1);
    step();

    // Load-use on rt only counts when rt is read
    idle();
    ex_mem_read = 1'b1; ex_rd = 5'd6; id_rs = 5'd1; id_rt = 5'd6; id_uses_rt = 1'b0;
    #1;
    chk("lu_rt_unused", pc_write, 1);
    id_uses_rt = 1'b1;
    #1;
    chk("lu_rt_used", pc_write, 0);
    step();
    chk("lu_rt_cnt", stall_cycles, 2);

    // Taken branch beats load-use
    idle();
    ex_branch_taken = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
    #1;
    chk("br_flush", if_id_flush, 1);
    chk("br_bubble", id_ex_bubble, 1);
    chk("br_pc_write", pc_write, 1);
    chk("br_stall_flag", stall_flag, 0);
    step();
    chk("br_cnt", stall_cycles, 2);

    // Forwarding
    idle();
    ex_rs = 5'd7; ex_rt = 5'd7; dm_rd = 5'd7; dm_reg_write = 1'b1;
    wb_rd = 5'd7; wb_reg_write = 1'b1;
    #1;
    chk("fwd_a_dm_wins", fwd_a, 2'b01);
    chk("fwd_b_dm_wins", fwd_b, 2'b01);
    dm_reg_write = 1'b0;
    #1;
    chk("fwd_a_wb", fwd_a, 2'b10);
    ex_rs = 5'd0; ex_rt = 5'd0; dm_rd = 5'd0; dm_reg_write = 1'b1; wb_rd = 5'd0;
    #1;
    chk("fwd_a_r0", fwd_a, 2'b00);
    chk("fwd_b_r0", fwd_b, 2'b00);
    ex_rt = 5'd9; wb_rd = 5'd9; dm_rd = 5'd4;
    #1;
    chk("fwd_b_wb", fwd_b, 2'b10);
    chk("fwd_a_none", fwd_a, 2'b00);
    step();

    // Reset pulse so the memory-wait stall count starts from zero
    idle();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    step();
    chk("pulse_cnt", stall_cycles, 0);

    // dm_busy for 3 cycles
    dm_busy = 1'b1; ex_rs = 5'd7; dm_rd = 5'd7; dm_reg_write = 1'b1;
    #1;
    chk("mw1_state", state, 0);
    chk("mw1_pc_write", pc_write, 0);
    chk("mw1_if_id_write", if_id_write, 0);
    chk("mw1_hold", pipe_hold, 1);
    chk("mw1_bubble", id_ex_bubble, 0);
    chk("mw1_stall_flag", stall_flag, 1);
    chk("mw1_fwd_a", fwd_a, 2'b01);
    step();
    chk("mw2_state", state, 1);
    chk("mw2_hold", pipe_hold, 1);
    step();
    chk("mw3_state", state, 1);
    chk("mw3_hold", pipe_hold, 1);
    step();
    dm_busy = 1'b0; ex_branch_taken = 1'b1;
    #1;
    chk("mw4_state", state, 1);
    chk("mw4_flush", if_id_flush, 1);
    chk("mw4_pc_write", pc_write, 1);
    chk("mw4_hold", pipe_hold, 0);
    chk("mw4_cnt", stall_cycles, 3);
    step();
    idle();
    #1;
    chk("mw_exit_state", state, 0);
    chk("mw_exit_cnt", stall_cycles, 3);

    // dm_busy held 16 cycles: timeout and counter saturation
    dm_busy = 1'b1;
    repeat (15) step();
    chk("to15_state", state, 1);
    chk("to15_timeout", mem_timeout, 0);
    chk("to15_cnt_sat", stall_cycles, 15);
    step();
    chk("to16_state", state, 2);
    chk("to16_timeout", mem_timeout, 1);
    dm_busy = 1'b0; ex_branch_taken = 1'b1; ex_rt = 5'd9; wb_rd = 5'd9; wb_reg_write = 1'b1;
    #1;
    chk("err_state", state, 2);
    chk("err_pc_write", pc_write, 0);
    chk("err_hold", pipe_hold, 1);
    chk("err_flush", if_id_flush, 0);
    chk("err_fwd_b", fwd_b, 2'b10);
    step();
    chk("err_sticky_state", state, 2);
    chk("err_sticky_timeout", mem_timeout, 1);
    chk("err_cnt_sat", stall_cycles, 15);

    // Asynchronous reset out of ERROR
    idle();
    reset = 1'b0;
    #1;
    chk("rst_err_state", state, 0);
    chk("rst_err_timeout", mem_timeout, 0);
    chk("rst_err_cnt", stall_cycles, 0);
    chk("rst_err_bubble", id_ex_bubble, 1);
    reset = 1'b1;
    step();
    chk("post_err_state", state, 0);
    chk("post_err_pc_write", pc_write, 1);

    // Asynchronous reset in the middle of MEM_WAIT
    dm_busy = 1'b1;
    step();
    step();
    chk("mid_mw_state", state, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_state", state, 0);
    chk("mid_rst_hold", pipe_hold, 0);
    chk("mid_rst_pc_write", pc_write, 0);
    chk("mid_rst_bubble", id_ex_bubble, 1);
    chk("mid_rst_stall_flag", stall_flag, 0);
    dm_busy = 1'b0;
    reset = 1'b1;
    step();
    chk("mid_post_state", state, 0);
    chk("mid_post_timeout", mem_timeout, 0);

    // A fresh 15-cycle wait stays below the timeout
    dm_busy = 1'b1;
    repeat (15) step();
    chk("fresh15_state", state, 1);
    dm_busy = 1'b0;
    step();
    chk("fresh_exit_state", state, 0);
    chk("fresh_timeout", mem_timeout, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
